// File: rtl/cache_pkg.sv
// Shared encodings for the single-line cache store: request opcodes and FSM states.
package cache_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_READ       = 3'b000,
    OP_WRITE      = 3'b001,
    OP_FILL       = 3'b010,
    OP_INVALIDATE = 3'b011,
    OP_WRITEBACK  = 3'b100
  } cache_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } cache_state_e;

endpackage

// File: rtl/cache_line_store_if.sv
// Request/response and writeback signals of one cache line. The slave modport is the
// line itself; the master modport is the set controller plus memory side.
interface cache_line_store_if #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 8
);
  import cache_pkg::*;

  localparam int OFF_W = $clog2(WORDS);

  logic              enable;
  logic [OP_W-1:0]   op;
  logic [TAG_W-1:0]  tag_in;
  logic [OFF_W-1:0]  offset;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] data_out;
  logic              ack;
  logic              hit;
  logic              busy;
  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  tag_out;
  logic              wb_valid;
  logic              wb_ready;
  logic [WORD_W-1:0] wb_data;
  logic [OFF_W-1:0]  wb_offset;

  modport master (
    output enable, op, tag_in, offset, data_in, wb_ready,
    input  data_out, ack, hit, busy, line_valid, line_dirty, tag_out,
           wb_valid, wb_data, wb_offset
  );

  modport slave (
    input  enable, op, tag_in, offset, data_in, wb_ready,
    output data_out, ack, hit, busy, line_valid, line_dirty, tag_out,
           wb_valid, wb_data, wb_offset
  );

endinterface

// File: rtl/cache_word_array.sv
// Data words of one cache line: one synchronous write port and two asynchronous read
// ports, one for requests and one for the writeback stream. Contents are not reset.
module cache_word_array #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 4,
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [OFF_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [OFF_W-1:0]  raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [OFF_W-1:0]  raddr_b,
  output logic [WORD_W-1:0] rdata_b
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/cache_line_store.sv
// One cache line: tag, per-word fill bits and dirty bit around a word array, serving
// READ/WRITE/FILL/INVALIDATE requests and streaming a dirty line back to memory.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  cache_line_store_if.slave bus
);

  localparam int OFF_W = $clog2(WORDS);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);
  localparam logic [WORDS-1:0] WORD0_MASK = WORDS'(1);

  cache_state_e      state, state_n;
  logic [TAG_W-1:0]  tag_r, tag_n;
  logic [WORDS-1:0]  fill_r, fill_n;
  logic              dirty_r, dirty_n;
  logic [WORD_W-1:0] data_out_r, data_out_n;
  logic              ack_r, ack_n;
  logic              hit_r, hit_n;
  logic              busy_r, busy_n;
  logic              wb_valid_r, wb_valid_n;
  logic [OFF_W-1:0]  wb_offset_r, wb_offset_n;
  logic [WORD_W-1:0] wb_data_r, wb_data_n;

  logic              we;
  logic [OFF_W-1:0]  waddr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] req_rd_data;
  logic [OFF_W-1:0]  wb_rd_addr;
  logic [WORD_W-1:0] wb_rd_data;

  logic              line_valid;
  logic              match;
  logic [WORDS-1:0]  off_mask;

  assign line_valid = &fill_r;
  assign match      = line_valid && (bus.tag_in == tag_r);
  assign off_mask   = WORD0_MASK << bus.offset;

  // Preload the word the stream will present after the next edge: word 0 when a
  // writeback starts, otherwise the successor of the word currently on the bus.
  assign wb_rd_addr = (state == ST_WB) ? wb_offset_r + OFF_W'(1) : '0;

  cache_word_array #(
    .WORD_W(WORD_W),
    .WORDS (WORDS)
  ) u_words (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(bus.offset),
    .rdata_a(req_rd_data),
    .raddr_b(wb_rd_addr),
    .rdata_b(wb_rd_data)
  );

  always_comb begin
    state_n     = state;
    tag_n       = tag_r;
    fill_n      = fill_r;
    dirty_n     = dirty_r;
    data_out_n  = data_out_r;
    ack_n       = 1'b0;
    hit_n       = 1'b0;
    busy_n      = busy_r;
    wb_valid_n  = wb_valid_r;
    wb_offset_n = wb_offset_r;
    wb_data_n   = wb_data_r;
    we          = 1'b0;
    waddr       = bus.offset;
    wdata       = bus.data_in;

    unique case (state)
      ST_IDLE: begin
        if (bus.enable) begin
          ack_n = 1'b1;
          case (bus.op)
            OP_READ: begin
              hit_n = match;
              if (match) begin
                data_out_n = req_rd_data;
              end
            end
            OP_WRITE: begin
              hit_n = match;
              if (match) begin
                we      = 1'b1;
                dirty_n = 1'b1;
              end
            end
            OP_FILL: begin
              we = 1'b1;
              // A different tag or an empty line starts a fresh line around this word.
              if ((bus.tag_in != tag_r) || (fill_r == '0)) begin
                tag_n   = bus.tag_in;
                fill_n  = off_mask;
                dirty_n = 1'b0;
              end else begin
                fill_n = fill_r | off_mask;
              end
              hit_n = (&fill_n) && !line_valid;
            end
            OP_INVALIDATE: begin
              hit_n   = line_valid;
              fill_n  = '0;
              dirty_n = 1'b0;
            end
            OP_WRITEBACK: begin
              if (line_valid && dirty_r) begin
                ack_n       = 1'b0;
                state_n     = ST_WB;
                busy_n      = 1'b1;
                wb_valid_n  = 1'b1;
                wb_offset_n = '0;
                wb_data_n   = wb_rd_data;
              end
            end
            default: begin
              hit_n = 1'b0;
            end
          endcase
        end
      end

      ST_WB: begin
        if (wb_valid_r && bus.wb_ready) begin
          if (wb_offset_r == LAST_OFF) begin
            wb_valid_n  = 1'b0;
            wb_offset_n = '0;
            busy_n      = 1'b0;
            dirty_n     = 1'b0;
            ack_n       = 1'b1;
            hit_n       = 1'b1;
            state_n     = ST_IDLE;
          end else begin
            wb_offset_n = wb_offset_r + OFF_W'(1);
            wb_data_n   = wb_rd_data;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r       <= '0;
      fill_r      <= '0;
      dirty_r     <= 1'b0;
      data_out_r  <= '0;
      ack_r       <= 1'b0;
      hit_r       <= 1'b0;
      busy_r      <= 1'b0;
      wb_valid_r  <= 1'b0;
      wb_offset_r <= '0;
      wb_data_r   <= '0;
    end else begin
      tag_r       <= tag_n;
      fill_r      <= fill_n;
      dirty_r     <= dirty_n;
      data_out_r  <= data_out_n;
      ack_r       <= ack_n;
      hit_r       <= hit_n;
      busy_r      <= busy_n;
      wb_valid_r  <= wb_valid_n;
      wb_offset_r <= wb_offset_n;
      wb_data_r   <= wb_data_n;
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.ack        = ack_r;
  assign bus.hit        = hit_r;
  assign bus.busy       = busy_r;
  assign bus.line_valid = line_valid;
  assign bus.line_dirty = dirty_r;
  assign bus.tag_out    = tag_r;
  assign bus.wb_valid   = wb_valid_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.wb_offset  = wb_offset_r;

endmodule

// File: tb/tb_cache_line_store.sv
// Directed bench for cache_line_store: expected ack results are queued when a request is
// driven and compared when the line acknowledges it.
module tb_cache_line_store;
  import cache_pkg::*;

  localparam int WORD_W = 16;
  localparam int WORDS  = 4;
  localparam int TAG_W  = 8;

  typedef struct {
    string             tag;
    logic              hit;
    logic              chk_data;
    logic [WORD_W-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   waited;
  int   idx;
  exp_t sb[$];
  logic [WORD_W-1:0] exp_words [WORDS];
  logic              ready_pat [6];

  cache_line_store_if #(.WORD_W(WORD_W), .WORDS(WORDS), .TAG_W(TAG_W)) bus ();

  cache_line_store #(.WORD_W(WORD_W), .WORDS(WORDS), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [2:0] op,
                                input logic [TAG_W-1:0] t, input logic [1:0] off,
                                input logic [WORD_W-1:0] d, input logic exp_hit,
                                input logic chk, input logic [WORD_W-1:0] exp_d);
    exp_t e;
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.op      = op;
    bus.tag_in  = t;
    bus.offset  = off;
    bus.data_in = d;
    e.tag       = tag;
    e.hit       = exp_hit;
    e.chk_data  = chk;
    e.data      = exp_d;
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    bus.enable = 1'b0;
    while (bus.ack !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    check_value("ack_seen", bus.ack, 1);
    check_value("sb_pending", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_value({e.tag, "_hit"}, bus.hit, e.hit);
      if (e.chk_data) begin
        check_value({e.tag, "_data"}, bus.data_out, e.data);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [TAG_W-1:0] t,
                        input logic [1:0] off, input logic [WORD_W-1:0] d,
                        input logic exp_hit, input logic chk, input logic [WORD_W-1:0] exp_d);
    apply_stimulus(tag, op, t, off, d, exp_hit, chk, exp_d);
    check_output();
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.op       = '0;
    bus.tag_in   = '0;
    bus.offset   = '0;
    bus.data_in  = '0;
    bus.wb_ready = 1'b0;

    #1;
    check_value("rst_ack", bus.ack, 0);
    check_value("rst_hit", bus.hit, 0);
    check_value("rst_busy", bus.busy, 0);
    check_value("rst_wb_valid", bus.wb_valid, 0);
    check_value("rst_wb_offset", bus.wb_offset, 0);
    check_value("rst_wb_data", bus.wb_data, 0);
    check_value("rst_valid", bus.line_valid, 0);
    check_value("rst_dirty", bus.line_dirty, 0);
    check_value("rst_tag", bus.tag_out, 0);
    check_value("rst_data_out", bus.data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    run_op("rd_empty", OP_READ, 8'h12, 2'd0, 16'h0, 1'b0, 1'b1, 16'h0000);
    check_value("empty_valid", bus.line_valid, 0);

    for (int i = 0; i < 4; i++) begin
      run_op("fill12", OP_FILL, 8'h12, 2'(i), 16'hA000 + 16'(i), (i == 3), 1'b0, 16'h0);
    end
    check_value("fill12_valid", bus.line_valid, 1);
    check_value("fill12_tag", bus.tag_out, 8'h12);
    check_value("fill12_dirty", bus.line_dirty, 0);

    run_op("rd_hit", OP_READ, 8'h12, 2'd2, 16'h0, 1'b1, 1'b1, 16'hA002);
    run_op("wr_hit", OP_WRITE, 8'h12, 2'd1, 16'hBEEF, 1'b1, 1'b1, 16'hA002);
    check_value("wr_hit_dirty", bus.line_dirty, 1);
    run_op("wr_miss", OP_WRITE, 8'h34, 2'd0, 16'hDEAD, 1'b0, 1'b1, 16'hA002);
    check_value("wr_miss_dirty", bus.line_dirty, 1);
    check_value("wr_miss_tag", bus.tag_out, 8'h12);
    run_op("rd_w0", OP_READ, 8'h12, 2'd0, 16'h0, 1'b1, 1'b1, 16'hA000);
    run_op("rd_w1", OP_READ, 8'h12, 2'd1, 16'h0, 1'b1, 1'b1, 16'hBEEF);
    run_op("rd_miss", OP_READ, 8'h34, 2'd2, 16'h0, 1'b0, 1'b1, 16'hBEEF);

    // Stalled writeback; enable pulses while busy must be ignored and leave data_out alone.
    exp_words = '{16'hA000, 16'hBEEF, 16'hA002, 16'hA003};
    ready_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_stimulus("wb_dirty", OP_WRITEBACK, 8'h12, 2'd0, 16'h0, 1'b1, 1'b1, 16'hBEEF);
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_value("wb_valid", bus.wb_valid, 1);
      check_value("wb_busy", bus.busy, 1);
      check_value("wb_no_ack", bus.ack, 0);
      check_value("wb_offset", bus.wb_offset, idx);
      check_value("wb_data", bus.wb_data, exp_words[idx]);
      bus.wb_ready = ready_pat[i];
      bus.enable   = !ready_pat[i];
      bus.op       = OP_READ;
      bus.tag_in   = 8'h12;
      bus.offset   = 2'd2;
      if (ready_pat[i]) idx++;
    end
    check_output();
    bus.wb_ready = 1'b0;
    check_value("wb_end_valid", bus.wb_valid, 0);
    check_value("wb_end_busy", bus.busy, 0);
    check_value("wb_end_dirty", bus.line_dirty, 0);
    check_value("wb_end_offset", bus.wb_offset, 0);
    check_value("wb_end_line", bus.line_valid, 1);

    run_op("wb_clean", OP_WRITEBACK, 8'h12, 2'd0, 16'h0, 1'b0, 1'b0, 16'h0);
    check_value("wb_clean_valid", bus.wb_valid, 0);
    check_value("wb_clean_busy", bus.busy, 0);

    run_op("fill55", OP_FILL, 8'h55, 2'd3, 16'h5503, 1'b0, 1'b0, 16'h0);
    check_value("fill55_tag", bus.tag_out, 8'h55);
    check_value("fill55_valid", bus.line_valid, 0);
    check_value("fill55_dirty", bus.line_dirty, 0);
    for (int i = 0; i < 3; i++) begin
      run_op("fill55b", OP_FILL, 8'h55, 2'(i), 16'h5500 + 16'(i), (i == 2), 1'b0, 16'h0);
    end
    check_value("fill55_full", bus.line_valid, 1);

    run_op("inv_valid", OP_INVALIDATE, 8'h00, 2'd0, 16'h0, 1'b1, 1'b0, 16'h0);
    check_value("inv_line", bus.line_valid, 0);
    check_value("inv_tag_kept", bus.tag_out, 8'h55);
    run_op("inv_empty", OP_INVALIDATE, 8'h55, 2'd0, 16'h0, 1'b0, 1'b0, 16'h0);
    run_op("undef_op", 3'b111, 8'h55, 2'd0, 16'h0, 1'b0, 1'b1, 16'hBEEF);

    for (int i = 0; i < 4; i++) begin
      run_op("fill66", OP_FILL, 8'h66, 2'(i), 16'hC000 + 16'(i), (i == 3), 1'b0, 16'h0);
    end
    run_op("wr66", OP_WRITE, 8'h66, 2'd0, 16'h1234, 1'b1, 1'b1, 16'hBEEF);

    // Reset lands while word 2 is on the writeback bus.
    apply_stimulus("wb_abort", OP_WRITEBACK, 8'h66, 2'd0, 16'h0, 1'b1, 1'b0, 16'h0);
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
    waited = 0;
    while (bus.wb_offset !== 2'd2 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_value("abort_offset", bus.wb_offset, 2);
    check_value("abort_data", bus.wb_data, 16'hC002);
    rst_n = 1'b0;
    #1;
    check_value("abort_wb_valid", bus.wb_valid, 0);
    check_value("abort_busy", bus.busy, 0);
    check_value("abort_line", bus.line_valid, 0);
    check_value("abort_dirty", bus.line_dirty, 0);
    sb.delete();
    bus.wb_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("rd_after_rst", OP_READ, 8'h66, 2'd0, 16'h0, 1'b0, 1'b1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
